puf_reader: RTL

PUF_READER -- requirements
Module: puf_reader

---
 rtl/puf_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/puf_reader.sv
// puf_reader: sequences one evaluate-and-read pass over a PUF array.
// The array is cleared (puf_reset), allowed to settle (puf_start), then every
// word is fetched in ascending address order and handed out on a
// valid/ready stream. All outputs come straight from flops.
module puf_reader #(
    parameter int ADDR_BITS     = 4,
    parameter int OUT_BITS      = 8,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    output logic                 busy,
    output logic                 puf_reset,
    output logic                 puf_start,
    output logic [ADDR_BITS-1:0] puf_addr,
    input  logic [OUT_BITS-1:0]  puf_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_BITS-1:0]  m_data,
    output logic                 m_last,
    output logic                 done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_EVAL = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    // Two cycles from an address change to the capture of its word.
    localparam logic [7:0] WAIT_LOAD   = 8'd2;

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    logic [2:0]           state_q,     state_d;
    logic [7:0]           cnt_q,       cnt_d;
    logic                 busy_q,      busy_d;
    logic                 puf_reset_q, puf_reset_d;
    logic                 puf_start_q, puf_start_d;
    logic [ADDR_BITS-1:0] puf_addr_q,  puf_addr_d;
    logic                 m_valid_q,   m_valid_d;
    logic [OUT_BITS-1:0]  m_data_q,    m_data_d;
    logic                 m_last_q,    m_last_d;
    logic                 done_q,      done_d;

    // Next-state and next-output computation for the pass sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        puf_reset_d = puf_reset_q;
        puf_start_d = puf_start_q;
        puf_addr_d  = puf_addr_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d     = 1'b0;
                puf_addr_d = '0;
                // done_q high means this is the done cycle: a req here is dropped.
                if (req && !done_q) begin
                    state_d     = S_CLR;
                    cnt_d       = RST_LOAD;
                    busy_d      = 1'b1;
                    puf_reset_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                if (cnt_q <= 8'd1) begin
                    state_d     = S_EVAL;
                    cnt_d       = SETTLE_LOAD;
                    puf_reset_d = 1'b0;
                    puf_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_EVAL: begin
                if (cnt_q <= 8'd1) begin
                    state_d     = S_WAIT;
                    cnt_d       = WAIT_LOAD;
                    puf_start_d = 1'b0;
                    puf_addr_d  = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    state_d   = S_SEND;
                    cnt_d     = 8'd0;
                    m_data_d  = puf_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (puf_addr_q == ADDR_MAX);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SEND: begin
                // Word, last flag and address are frozen until accepted.
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (puf_addr_q == ADDR_MAX) begin
                        state_d = S_FIN;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d    = S_WAIT;
                        cnt_d      = WAIT_LOAD;
                        puf_addr_d = puf_addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_FIN: begin
                // busy stays up through the done cycle and drops in IDLE.
                state_d    = S_IDLE;
                done_d     = 1'b1;
                puf_addr_d = '0;
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = 8'd0;
                busy_d      = 1'b0;
                puf_reset_d = 1'b0;
                puf_start_d = 1'b0;
                puf_addr_d  = '0;
                m_valid_d   = 1'b0;
                m_last_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            puf_reset_q <= 1'b0;
            puf_start_q <= 1'b0;
            puf_addr_q  <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            puf_reset_q <= puf_reset_d;
            puf_start_q <= puf_start_d;
            puf_addr_q  <= puf_addr_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign puf_reset = puf_reset_q;
    assign puf_start = puf_start_q;
    assign puf_addr  = puf_addr_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign done      = done_q;

endmodule
